ifid_pipe: RTL and testbench
============================

IFID_PIPE -- requirements
Module: ifid_pipe

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set the instruction memory depth in 32-bit words; it is a power of two and at least 4.
REQ-002 Parameter WB_LAT, default 3, SHALL set the number of cycles from issue to register-file write in the downstream idexwb_pipe; range 1..8.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 go  input  1  SHALL be the start-fetch request, sampled in IDLE or HALT.
REQ-006 ld_en  input  1  SHALL be the instruction-memory write enable.
REQ-007 ld_addr  input  log2(DEPTH)  SHALL be the instruction-memory write address.
REQ-008 ld_data  input  32  SHALL be the instruction-memory write data.
REQ-009 opcode  output  3  SHALL be the issued opcode: NOP 000, ADD 001, MUL 010, ADDI 011.
REQ-010 Rs1, Rs2, Rd  output  5 each  SHALL be the issued source and destination register numbers.
REQ-011 imm  output  12 signed  SHALL be the issued immediate.
REQ-012 start  output  1  SHALL flag a valid issued instruction this cycle.
REQ-013 halted  output  1  SHALL be high while in HALT.
REQ-014 pc  output  log2(DEPTH)  SHALL be the current fetch address.

Function
REQ-015 Instruction word fields SHALL be: imm [31:20], Rs1 [19:15], Rs2 [14:10], Rd [9:5], reserved [4:3], op [2:0]; op 111 is HALT; ops 100, 101 and 110 are illegal.
REQ-016 The FSM SHALL have three states, IDLE, RUN and HALT, with these transitions: IDLE-go->RUN, RUN-HALT decoded->HALT, HALT-go->RUN.
REQ-017 Entry to RUN SHALL set pc=0 and clear the fetch register (IR) valid bit.
REQ-018 In RUN without stall, each edge SHALL load IR<=IMEM[pc], set IR valid, and advance pc<=pc+1, wrapping DEPTH-1 to 0.
REQ-019 In RUN, each edge SHALL register the IR decode onto the outputs; start=1 only for a valid IR holding ADD, MUL or ADDI.
REQ-020 Issue latency SHALL be two edges: go sampled at edge n gives the IMEM[0] issue at edge n+2.
REQ-021 A bubble SHALL drive start=0, opcode=000 and Rs1=Rs2=Rd=0, imm=0.
REQ-022 An illegal op or a NOP SHALL issue a bubble and shall not stall.
REQ-023 A HALT in IR SHALL issue a bubble, move the FSM to HALT and discard any fetched word; pc holds.
REQ-024 A scoreboard SHALL hold the Rd of each of the last WB_LAT issue slots; a bubble or Rd=0 records no entry; it shifts every RUN edge.
REQ-025 The hazard check SHALL compare Rs1 against the scoreboard for ADD, MUL and ADDI, and Rs2 for ADD and MUL only; Rs1=0 or Rs2=0 never matches.
REQ-026 On a hazard, the edge SHALL issue a bubble and hold IR, IR valid and pc.
REQ-027 A dependent instruction SHALL therefore issue exactly WB_LAT+1 edges after its producer.
REQ-028 ld_en SHALL write IMEM[ld_addr]<=ld_data in IDLE or HALT; in RUN it is ignored.
REQ-029 go in RUN SHALL be ignored.
REQ-030 go and ld_en on the same edge in IDLE SHALL both take effect; the write lands before the first fetch.
REQ-031 In IDLE and HALT, outputs SHALL hold the bubble value.

Reset
REQ-032 rst low SHALL immediately force the FSM to IDLE, pc=0, IR invalid, the scoreboard empty, all issue outputs to the bubble value, and halted=0, even mid-RUN.
REQ-033 IMEM contents SHALL not be affected by reset.

Verification
REQ-034 Load IMEM[0..4] = 0x00500023, 0x00600043, 0x00700063, 0x00800083, 0x00000007, then pulse go at edge 0 -> start=1 at edges 2..5 with opcode 011, Rd 1..4 and imm 5..8; halted=1 after edge 6.
REQ-035 Load IMEM[0] = 0x00500023 (ADDI r1) and IMEM[1] = 0x00008861 (ADD r3,r1,r2) with WB_LAT=3 -> ADDI issues at edge 2, bubbles at edges 3-5, ADD issues at edge 6 with Rs1=1, Rs2=2, Rd=3.
REQ-036 ADDI Rd=0 followed by ADD Rs1=0 -> no stall; ADDI r1 followed by ADDI with Rs2 field=1 and Rs1=0 -> no stall, back-to-back issue.
REQ-037 IMEM[2]=0x00000005 (illegal op) -> bubble at edge 4, no stall, IMEM[3] issues at edge 5.
REQ-038 Drive ld_en during RUN -> IMEM unchanged; DEPTH=4 with no HALT -> pc wraps 3->0 and IMEM[0] reissues.
REQ-039 Assert rst low between edges during a stall -> outputs are the bubble value with no clock edge; go after release restarts at pc=0.

Source files
------------

// File: rtl/ifid_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ifid_pipe
// Brief    : Instruction fetch/decode/issue stage with a RAW scoreboard that
//            stalls dependent instructions until the downstream write lands.
// Revision : 1.0
// ============================================================================
module ifid_pipe #(
    parameter  int DEPTH  = 64,
    parameter  int WB_LAT = 3,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go_i,
    input  logic                 ld_en_i,
    input  logic [AW-1:0]        ld_addr_i,
    input  logic [31:0]          ld_data_i,
    output logic [2:0]           opcode_o,
    output logic [4:0]           rs1_o,
    output logic [4:0]           rs2_o,
    output logic [4:0]           rd_o,
    output logic signed [11:0]   imm_o,
    output logic                 start_o,
    output logic                 halted_o,
    output logic [AW-1:0]        pc_o
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_ADDI = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [31:0]   ir_q, ir_d;
    logic          irv_q, irv_d;
    logic [2:0]    opcode_q, opcode_d;
    logic [4:0]    rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [11:0]   imm_q, imm_d;
    logic          start_q, start_d;
    logic [4:0]    sb_q [WB_LAT];
    logic [4:0]    sb_d [WB_LAT];

    logic [31:0]   imem [DEPTH];
    logic [31:0]   w_fetch;
    logic [2:0]    w_op;
    logic [4:0]    w_rs1, w_rs2, w_rd;
    logic [11:0]   w_imm;
    logic          w_legal, w_use_rs2, w_is_halt, w_hazard, w_stall;
    logic [4:0]    w_sb_in;
    logic          w_unused;

    // Loads are only honoured outside RUN so the program cannot change under the fetcher.
    always_ff @(posedge clk) begin
        if (ld_en_i && (state_q != S_RUN)) begin
            imem[ld_addr_i] <= ld_data_i;
        end
    end

    assign w_fetch   = imem[pc_q];
    assign w_op      = ir_q[2:0];
    assign w_rd      = ir_q[9:5];
    assign w_rs2     = ir_q[14:10];
    assign w_rs1     = ir_q[19:15];
    assign w_imm     = ir_q[31:20];
    assign w_unused  = ^ir_q[4:3];

    assign w_legal   = (w_op == OP_ADD) || (w_op == OP_MUL) || (w_op == OP_ADDI);
    assign w_use_rs2 = (w_op == OP_ADD) || (w_op == OP_MUL);
    assign w_is_halt = (w_op == OP_HALT);

    // A zero scoreboard slot never matches, which also makes r0 sources hazard-free.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < WB_LAT; i++) begin
            if ((sb_q[i] != 5'd0) && (sb_q[i] == w_rs1)) begin
                w_hazard = 1'b1;
            end
            if (w_use_rs2 && (sb_q[i] != 5'd0) && (sb_q[i] == w_rs2)) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign w_stall = irv_q && w_legal && w_hazard;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        irv_d    = irv_q;
        opcode_d = OP_NOP;
        rs1_d    = 5'd0;
        rs2_d    = 5'd0;
        rd_d     = 5'd0;
        imm_d    = 12'd0;
        start_d  = 1'b0;
        w_sb_in  = 5'd0;
        for (int i = 0; i < WB_LAT; i++) begin
            sb_d[i] = sb_q[i];
        end

        case (state_q)
            S_IDLE, S_HALT: begin
                if (go_i) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    irv_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (irv_q && w_is_halt) begin
                    state_d = S_HALT;
                    irv_d   = 1'b0;
                end else if (!w_stall) begin
                    if (irv_q && w_legal) begin
                        opcode_d = w_op;
                        rs1_d    = w_rs1;
                        rs2_d    = w_rs2;
                        rd_d     = w_rd;
                        imm_d    = w_imm;
                        start_d  = 1'b1;
                        w_sb_in  = w_rd;
                    end
                    ir_d  = w_fetch;
                    irv_d = 1'b1;
                    pc_d  = pc_q + AW'(1);
                end
                sb_d[0] = w_sb_in;
                for (int i = 1; i < WB_LAT; i++) begin
                    sb_d[i] = sb_q[i-1];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            irv_q    <= 1'b0;
            opcode_q <= OP_NOP;
            rs1_q    <= 5'd0;
            rs2_q    <= 5'd0;
            rd_q     <= 5'd0;
            imm_q    <= 12'd0;
            start_q  <= 1'b0;
            for (int i = 0; i < WB_LAT; i++) begin
                sb_q[i] <= 5'd0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            irv_q    <= irv_d;
            opcode_q <= opcode_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            start_q  <= start_d;
            for (int i = 0; i < WB_LAT; i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end

    assign opcode_o = opcode_q;
    assign rs1_o    = rs1_q;
    assign rs2_o    = rs2_q;
    assign rd_o     = rd_q;
    assign imm_o    = imm_q;
    assign start_o  = start_q;
    assign halted_o = (state_q == S_HALT);
    assign pc_o     = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_ifid_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ifid_pipe
// Brief    : Randomised and directed programs for ifid_pipe, scored against a
//            program-order timing model through an expected-issue queue.
// Revision : 1.0
// ============================================================================
module tb_ifid_pipe;

    localparam int DEPTH  = 64;
    localparam int WB_LAT = 3;
    localparam int AW     = 6;
    localparam int BIG    = 32'h7fff_ffff;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              go_i;
    logic              ld_en_i;
    logic [AW-1:0]     ld_addr_i;
    logic [31:0]       ld_data_i;
    logic [2:0]        opcode_o;
    logic [4:0]        rs1_o, rs2_o, rd_o;
    logic signed [11:0] imm_o;
    logic              start_o;
    logic              halted_o;
    logic [AW-1:0]     pc_o;

    ifid_pipe #(.DEPTH(DEPTH), .WB_LAT(WB_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .go_i      (go_i),
        .ld_en_i   (ld_en_i),
        .ld_addr_i (ld_addr_i),
        .ld_data_i (ld_data_i),
        .opcode_o  (opcode_o),
        .rs1_o     (rs1_o),
        .rs2_o     (rs2_o),
        .rd_o      (rd_o),
        .imm_o     (imm_o),
        .start_o   (start_o),
        .halted_o  (halted_o),
        .pc_o      (pc_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] op;
        logic [4:0] rs1, rs2, rd;
        logic [11:0] imm;
    } exp_t;
    typedef struct {
        int         t;
        logic [4:0] rd;
    } prod_t;

    exp_t        exp_q[$];
    prod_t       hist[$];
    logic [31:0] mem [DEPTH];
    int          rt = 0;
    int          checks = 0;
    int          failures = 0;
    int          exp_halt_edge = BIG;
    bit          mon_en = 1'b0;
    exp_t        e_mon;

    function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [11:0] imm);
        return {imm, rs1, rs2, rd, 2'b00, op};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Program-order timing model: each instruction takes the next slot unless a
    // producer issued within the last WB_LAT RUN edges wrote one of its sources.
    task automatic model(input int g, input int limit, output int h, output int hpc);
        int r0, nxt, pc, t, ab;
        logic [31:0] w;
        logic [2:0]  op;
        logic        legal, u2;
        exp_t        e;
        h = -1; hpc = 0;
        r0 = rt; nxt = r0 + 1; pc = 0;
        while (1) begin
            ab = g + 1 + (nxt - r0);
            if (ab > g + limit) break;
            w  = mem[pc];
            op = w[2:0];
            if (op == 3'b111) begin
                h   = ab;
                hpc = (pc + 1) % DEPTH;
                rt  = nxt + 1;
                break;
            end
            legal = (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
            u2    = (op == 3'd1) || (op == 3'd2);
            if (legal) begin
                t = nxt;
                foreach (hist[i]) begin
                    if (hist[i].rd != 5'd0 &&
                        ((w[19:15] == hist[i].rd) || (u2 && w[14:10] == hist[i].rd))) begin
                        if (hist[i].t + WB_LAT + 1 > t) t = hist[i].t + WB_LAT + 1;
                    end
                end
                ab = g + 1 + (t - r0);
                if (ab > g + limit) break;
                e.cyc = ab; e.op = op; e.rs1 = w[19:15]; e.rs2 = w[14:10];
                e.rd = w[9:5]; e.imm = w[31:20];
                exp_q.push_back(e);
                if (w[9:5] != 5'd0) hist.push_back('{t, w[9:5]});
                nxt = t + 1;
            end else begin
                nxt = nxt + 1;
            end
            pc = (pc + 1) % DEPTH;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            checks++;
            if (halted_o !== (cyc >= exp_halt_edge)) begin
                failures++;
                $display("FAIL halted cyc=%0d actual=%0b expected=%0b", cyc, halted_o, cyc >= exp_halt_edge);
            end
            checks++;
            if (start_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_issue cyc=%0d op=%0d rs1=%0d rs2=%0d rd=%0d expected=none",
                             cyc, opcode_o, rs1_o, rs2_o, rd_o);
                end else begin
                    e_mon = exp_q.pop_front();
                    if (e_mon.cyc != cyc || e_mon.op !== opcode_o || e_mon.rs1 !== rs1_o ||
                        e_mon.rs2 !== rs2_o || e_mon.rd !== rd_o || e_mon.imm !== imm_o) begin
                        failures++;
                        $display("FAIL issue actual cyc=%0d op=%0d rs1=%0d rs2=%0d rd=%0d imm=%0d expected cyc=%0d op=%0d rs1=%0d rs2=%0d rd=%0d imm=%0d",
                                 cyc, opcode_o, rs1_o, rs2_o, rd_o, imm_o,
                                 e_mon.cyc, e_mon.op, e_mon.rs1, e_mon.rs2, e_mon.rd, e_mon.imm);
                    end
                end
            end else if ({opcode_o, rs1_o, rs2_o, rd_o, imm_o} !== 30'd0) begin
                failures++;
                $display("FAIL bubble cyc=%0d actual=0x%0h expected=0x0", cyc,
                         {opcode_o, rs1_o, rs2_o, rd_o, imm_o});
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_start", {31'd0, start_o}, 32'd0);
        chk("rst_bubble", {2'b00, opcode_o, rs1_o, rs2_o, rd_o, imm_o}, 32'd0);
        chk("rst_pc", {26'd0, pc_o}, 32'd0);
        chk("rst_halted", {31'd0, halted_o}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        hist.delete();
        exp_q.delete();
        rt = 0;
        exp_halt_edge = BIG;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        ld_en_i = 1'b1; ld_addr_i = AW'(a); ld_data_i = d;
        @(posedge clk);
        #1;
        ld_en_i = 1'b0;
        mem[a] = d;
    endtask

    // Word 0 is written on the same edge that samples go.
    task automatic do_run(input logic [31:0] w0, input int limit, input bit noise);
        int g, h, hpc, end_e;
        go_i = 1'b1; ld_en_i = 1'b1; ld_addr_i = '0; ld_data_i = w0;
        @(posedge clk);
        #1;
        go_i = 1'b0; ld_en_i = 1'b0;
        mem[0] = w0;
        g = cyc;
        model(g, limit, h, hpc);
        exp_halt_edge = (h >= 0) ? h : BIG;
        end_e = (h >= 0) ? h + 1 : g + limit;
        while (cyc < end_e) begin
            if (noise && (h < 0 || cyc + 1 <= h)) begin
                ld_en_i   = 1'($urandom_range(0, 1));
                ld_addr_i = AW'($urandom);
                ld_data_i = $urandom;
                go_i      = ($urandom_range(0, 7) == 0);
            end
            @(posedge clk);
            #1;
            ld_en_i = 1'b0; go_i = 1'b0;
        end
        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        if (h >= 0) begin
            chk("halt_pc", {26'd0, pc_o}, hpc);
            chk("halt_flag", {31'd0, halted_o}, 32'd1);
            @(posedge clk);
            #1;
        end else begin
            do_reset();
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [2:0]  op;
        int          r, hpos;
        rst_n = 1'b0; go_i = 1'b0; ld_en_i = 1'b0; ld_addr_i = '0; ld_data_i = '0;
        do_reset();
        mon_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) load(i, 32'd0);

        // Four ADDIs then HALT; word 0 lands together with go.
        load(1, 32'h0060_0043); load(2, 32'h0070_0063);
        load(3, 32'h0080_0083); load(4, 32'h0000_0007);
        do_run(32'h0050_0023, 300, 1'b0);

        // ADDI r1 then ADD r3,r1,r2: dependent issue waits WB_LAT+1 edges.
        load(1, 32'h0000_8861); load(2, 32'h0000_0007);
        do_run(32'h0050_0023, 300, 1'b0);

        // r0 never creates a hazard; ADDI ignores its rs2 field.
        load(1, enc(3'd1, 5'd5, 5'd0, 5'd0, 12'd0));
        load(2, enc(3'd3, 5'd1, 5'd0, 5'd0, 12'd1));
        load(3, enc(3'd3, 5'd2, 5'd0, 5'd1, 12'd2));
        load(4, 32'h0000_0007);
        do_run(enc(3'd3, 5'd0, 5'd0, 5'd0, 12'd9), 300, 1'b0);

        // Illegal op in slot 2 is a bubble without stalling.
        load(1, enc(3'd3, 5'd7, 5'd0, 5'd0, 12'd2));
        load(2, 32'h0000_0005);
        load(3, enc(3'd3, 5'd8, 5'd0, 5'd0, 12'd3));
        load(4, 32'h0000_0007);
        do_run(enc(3'd3, 5'd6, 5'd0, 5'd0, 12'd1), 300, 1'b0);

        // Reset lands mid-stall, then the same program restarts from pc 0.
        load(1, enc(3'd1, 5'd2, 5'd1, 5'd1, 12'd0));
        load(2, 32'h0000_0007);
        do_run(enc(3'd3, 5'd1, 5'd0, 5'd0, 12'd4), 3, 1'b0);
        do_run(enc(3'd3, 5'd1, 5'd0, 5'd0, 12'd4), 300, 1'b0);

        // Random programs; those without HALT run long enough to wrap pc.
        for (int p = 0; p < 6; p++) begin
            hpos = ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 40)) : -1;
            for (int i = 0; i < DEPTH; i++) begin
                r = $urandom_range(0, 9);
                if (r < 3)       op = 3'd1;
                else if (r < 5)  op = 3'd2;
                else if (r < 8)  op = 3'd3;
                else if (r == 8) op = 3'd0;
                else             op = 3'(4 + $urandom_range(0, 2));
                if (i == hpos) op = 3'b111;
                w = {12'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 2'($urandom), op};
                if (i == 0) mem[0] = w;
                else        load(i, w);
            end
            do_run(mem[0], (hpos >= 0) ? 300 : 200, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
